// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake and instruction-memory write bus of the loader.
//   master : stream source / system side (drives start, in_valid, in_data)
//   slave  : the loader (drives in_ready, IM_*, cpu_hold, done, error)
// Signals:
//   start            single-cycle request to begin a new load
//   in_valid/in_data stream byte offered by the source
//   in_ready         loader accepts a byte this cycle
//   IM_we/addr/data  instruction-memory write port (7-bit address, 16-bit word)
//   cpu_hold         processor held in reset while high
//   done / error     load finished with good / bad checksum
interface program_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        IM_we;
    logic [6:0]  IM_addr;
    logic [15:0] IM_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, IM_we, IM_addr, IM_data, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, IM_we, IM_addr, IM_data, cpu_hold, done, error
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: boot-time writer for the 128x16 instruction memory.
// Receives a count byte, 2N data bytes (high byte first) and an XOR checksum byte over a
// valid/ready stream, writes each word to sequential addresses starting at 0, and releases
// the processor (cpu_hold low) only after the whole image is written with a matching checksum.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous active-high reset
//   bus    program_loader_if.slave (stream in, IM write port out, status out)
// All outputs come from flops or from a decode of the state register only.
module program_loader #(
    parameter int unsigned WORDS = 128
) (
    input logic             Clk,
    input logic             Reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StCount, StHi, StLo, StWrite, StCheck, StDone, StErr
    } state_e;

    // Highest legal address; guards against wrap even if the limit were corrupted.
    localparam logic [6:0] MaxAddr = 7'(WORDS - 1);

    state_e      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [6:0]  limit_q, limit_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  csum_q, csum_d;

    logic in_ready;
    logic im_we;
    logic cpu_hold;
    logic done;
    logic error;
    logic accept;
    logic last_word;

    assign accept    = bus.in_valid & in_ready;
    assign last_word = (addr_q == limit_q) || (addr_q == MaxAddr);

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            limit_q <= '0;
            data_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            limit_q <= limit_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        limit_d = limit_q;
        data_d  = data_q;
        csum_d  = csum_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StCount;
            end
            StCount: begin
                if (accept) begin
                    limit_d = bus.in_data[6:0];
                    csum_d  = bus.in_data;
                    addr_d  = '0;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (accept) begin
                    data_d[15:8] = bus.in_data;
                    csum_d       = csum_q ^ bus.in_data;
                    state_d      = StLo;
                end
            end
            StLo: begin
                if (accept) begin
                    data_d[7:0] = bus.in_data;
                    csum_d      = csum_q ^ bus.in_data;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (last_word) begin
                    state_d = StCheck;
                end else begin
                    addr_d  = addr_q + 7'd1;
                    state_d = StHi;
                end
            end
            StCheck: begin
                if (accept) state_d = (bus.in_data == csum_q) ? StDone : StErr;
            end
            StDone, StErr: begin
                if (bus.start) state_d = StCount;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register only (no input-to-output paths)
    always_comb begin
        in_ready = 1'b0;
        im_we    = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state_q)
            StCount, StHi, StLo, StCheck: in_ready = 1'b1;
            StWrite: im_we = 1'b1;
            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            StErr: error = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.IM_we    = im_we;
    assign bus.IM_addr  = addr_q;
    assign bus.IM_data  = data_q;
    assign bus.cpu_hold = cpu_hold;
    assign bus.done     = done;
    assign bus.error    = error;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// A table of images with expected final status, random images checked against a simple
// reference model (expected writes = words in order at addresses 0..N-1, success iff the
// checksum byte equals the XOR of all preceding bytes), plus hand-written corner sequences.
module tb_program_loader;

    logic clk;
    logic rst;

    program_loader_if bus ();

    program_loader #(
        .WORDS(128)
    ) u_dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] img_words[$];
    logic [7:0]  img_cnt;
    logic [7:0]  img_csum;

    logic [6:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    typedef struct {
        logic [7:0]  cnt;
        logic [15:0] base;
        logic [7:0]  flip;
        int          gap;
        logic        exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.IM_we === 1'b1) begin
            wr_addr_q.push_back(bus.IM_addr);
            wr_data_q.push_back(bus.IM_data);
            check("ready_low_during_we", 32'(bus.in_ready), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        budget = 200;
        while (gap > 0 && int'($urandom_range(0, 99)) < gap && budget > 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            budget--;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget       = 200;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic make_image(input logic [7:0] cnt, input logic [15:0] base,
                              input logic [7:0] flip, input bit rnd);
        logic [7:0]  x;
        logic [15:0] w;
        img_words.delete();
        img_cnt = cnt;
        x       = cnt;
        for (int i = 0; i <= int'(cnt[6:0]); i++) begin
            w = rnd ? 16'($urandom) : base + 16'(i);
            img_words.push_back(w);
            x = x ^ w[15:8] ^ w[7:0];
        end
        img_csum = x ^ flip;
    endtask

    function automatic logic model_ok();
        logic [7:0] x;
        x = img_cnt;
        foreach (img_words[i]) x = x ^ img_words[i][15:8] ^ img_words[i][7:0];
        return x == img_csum;
    endfunction

    task automatic check_writes(input string tag);
        int n;
        n = int'(img_cnt[6:0]) + 1;
        check({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_write_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check({tag, "_write_data"}, 32'(wr_data_q[i]), 32'(img_words[i]));
        end
    endtask

    task automatic check_status(input string tag, input logic exp_done);
        check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
        check({tag, "_error"}, 32'(bus.error), 32'(!exp_done));
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    endtask

    // Called at a negedge with the loader in IDLE, DONE or ERR.
    task automatic run_load(input int gap, input logic exp_done, input string tag);
        int unsigned t0;
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_ready_after_start"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_hold_during_load"}, 32'(bus.cpu_hold), 32'd1);
        t0 = cyc;
        send_byte(img_cnt, gap);
        foreach (img_words[i]) begin
            send_byte(img_words[i][15:8], gap);
            send_byte(img_words[i][7:0], gap);
        end
        send_byte(img_csum, gap);
        bus.in_valid = 1'b0;
        check_status(tag, exp_done);
        if (gap == 0) check({tag, "_latency"}, cyc - t0, 32'(3 * (int'(img_cnt[6:0]) + 1) + 2));
        check_writes(tag);
    endtask

    initial begin
        logic [7:0] rc;
        int         rn;
        int         budget;
        logic       exp;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{cnt: 8'h00, base: 16'h1234, flip: 8'h00, gap: 0,  exp_done: 1'b1};
        vecs[1] = '{cnt: 8'h00, base: 16'h1234, flip: 8'h01, gap: 0,  exp_done: 1'b0};
        vecs[2] = '{cnt: 8'h00, base: 16'h1234, flip: 8'h00, gap: 0,  exp_done: 1'b1};
        vecs[3] = '{cnt: 8'h7F, base: 16'h0000, flip: 8'h00, gap: 0,  exp_done: 1'b1};
        vecs[4] = '{cnt: 8'h83, base: 16'hA5F0, flip: 8'h00, gap: 30, exp_done: 1'b1};
        vecs[5] = '{cnt: 8'h05, base: 16'hFFFE, flip: 8'h80, gap: 20, exp_done: 1'b0};

        // Reset values
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.IM_we), 32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_addr", 32'(bus.IM_addr), 32'd0);
        check("rst_data", 32'(bus.IM_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_not_ready", 32'(bus.in_ready), 32'd0);

        // Table-driven images
        for (int v = 0; v < 6; v++) begin
            make_image(vecs[v].cnt, vecs[v].base, vecs[v].flip, 1'b0);
            run_load(vecs[v].gap, vecs[v].exp_done, $sformatf("vec%0d", v));
        end

        // Reset mid-stream, asserted between edges
        make_image(8'h07, 16'h4000, 8'h00, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(img_cnt, 0);
        send_byte(img_words[0][15:8], 0);
        send_byte(img_words[0][7:0], 0);
        send_byte(img_words[1][15:8], 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_we", 32'(bus.IM_we), 32'd0);
        check("mid_rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("mid_rst_addr", 32'(bus.IM_addr), 32'd0);
        check("mid_rst_data", 32'(bus.IM_data), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_idle_ready", 32'(bus.in_ready), 32'd0);
        check("post_rst_no_writes", 32'(wr_addr_q.size()), 32'd0);
        check("post_rst_hold", 32'(bus.cpu_hold), 32'd1);
        bus.in_valid = 1'b0;

        // Random images against the reference model
        for (int r = 0; r < 8; r++) begin
            rn = int'($urandom_range(1, 16));
            rc = {1'($urandom_range(0, 1)), 7'(rn - 1)};
            make_image(rc, 16'h0000, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                       1'b1);
            exp = model_ok();
            run_load(int'($urandom_range(0, 40)), exp, $sformatf("rnd%0d", r));
        end

        // start pulses during HI and CHECK must be ignored
        make_image(8'h02, 16'hBEE0, 8'h00, 1'b0);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(img_cnt, 0);
        bus.start = 1'b1;
        send_byte(img_words[0][15:8], 0);
        bus.start = 1'b0;
        send_byte(img_words[0][7:0], 0);
        for (int i = 1; i < 3; i++) begin
            send_byte(img_words[i][15:8], 0);
            send_byte(img_words[i][7:0], 0);
        end
        bus.in_valid = 1'b0;
        budget       = 20;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("ign_reach_check", 32'(bus.in_ready), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(img_csum, 0);
        bus.in_valid = 1'b0;
        check_status("ign", model_ok());
        check_writes("ign");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the processor's 128×16 instruction memory. It accepts a program as a byte stream over a valid/ready handshake and writes each 16-bit instruction into sequential instruction-memory addresses. It holds the processor in reset until the whole image is written and its checksum matches, then releases the processor to run from address 0. It sits beside the processor at top level and drives the write port of the instruction memory that the controller reads through its 7-bit program counter.

## Interface
Parameters:
- `WORDS`, 128: instruction-memory depth. The address width is 7 bits and stays fixed in this block.

Ports:
- `Clk`  input  1  system clock; all state changes on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request to begin a new load.
- `in_valid`  input  1  `in_data` holds a byte.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `IM_we`  output  1  instruction-memory write enable, one-cycle pulse per word.
- `IM_addr`  output  7  instruction-memory write address.
- `IM_data`  output  16  instruction word to write.
- `cpu_hold`  output  1  high means the processor is held in reset.
- `done`  output  1  image loaded with a valid checksum.
- `error`  output  1  checksum mismatch on the last load.

## Operation
- Stream format, in order:
  - count byte `C`, where the word count `N` = `C[6:0]` + 1, giving 1..128. `C[7]` is ignored but included in the checksum.
  - `2N` data bytes, high byte first for each word.
  - one checksum byte equal to the XOR of the count byte and all data bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR.
- IDLE: `cpu_hold`=1. `start` → COUNT.
- COUNT: on an accepted byte, latch `N`-1 into the word limit, set the checksum to the byte, clear the address to 0, then → HI.
- HI: on an accepted byte, latch `IM_data[15:8]`, XOR the byte into the checksum, then → LO.
- LO: on an accepted byte, latch `IM_data[7:0]`, XOR the byte into the checksum, then → WRITE.
- WRITE: `IM_we`=1 for exactly one cycle with the current `IM_addr` and `IM_data`.
  - If `IM_addr` equals the limit → CHECK.
  - Otherwise increment `IM_addr` and → HI.
- CHECK: on an accepted byte:
  - byte equals the running checksum → DONE.
  - otherwise → ERR.
- DONE: `done`=1, `cpu_hold`=0.
- ERR: `error`=1, `cpu_hold`=1.
- From DONE or ERR, `start` → COUNT. This clears `done` and `error` and reasserts `cpu_hold` on the next cycle.
- `start` is ignored in COUNT, HI, LO, WRITE and CHECK.
- `in_ready` is high only in COUNT, HI, LO and CHECK. A byte is accepted only when `in_valid` and `in_ready` are both high at a rising edge.
- Bytes offered in IDLE, WRITE, DONE or ERR are not accepted. The source must hold them until `in_ready` is high.
- `IM_addr` never exceeds `N`-1, so no wrap-around occurs. A 128-word image ends at address 127.
- Memory contents already written are not rolled back on a checksum error. `cpu_hold` stays high until a successful load.

## Timing
- Reset values, applied immediately on `Reset` asserting, independent of `Clk`:
  - state IDLE;
  - `cpu_hold`=1;
  - `in_ready`=0, `IM_we`=0, `done`=0, `error`=0;
  - `IM_addr`=0, `IM_data`=0, checksum 0.
- Reset asserted mid-load aborts the load, with no further `IM_we`. The loader returns to IDLE, not COUNT, after `Reset` deasserts.
- `start` sampled in IDLE: `in_ready` goes high in the following cycle.
- The last data byte accepted in LO leads to `IM_we` high in the next cycle. `in_ready` is low during that cycle.
- Minimum load time with `in_valid` held high: 1 + 3`N` + 1 cycles from the first `in_ready` to DONE.
- `cpu_hold` falls and `done` rises in the same cycle, the first cycle in DONE. Both are registered outputs.
- All outputs are registered or decoded from the state register only. No input-to-output combinational path exists, including `in_valid` → `in_ready`.

## Test plan
- Reset mid-stream:
  - Stimulus: assert `Reset` asynchronously between edges.
  - Required response: all outputs take their reset values before the next edge. The state is IDLE, and bytes stay unaccepted until `start`.
- One-word image:
  - Stimulus: `start`, then bytes 0x00, 0x12, 0x34, checksum 0x26.
  - Required response: a single `IM_we` pulse at address 0 with data 0x1234. Then `done`=1 and `cpu_hold`=0.
- Full 128-word image:
  - Stimulus: count byte 0x7F, words 0x0000..0x007F, correct checksum.
  - Required response: 128 `IM_we` pulses at addresses 0..127 in order. No pulse at any other address. Then DONE.
- Checksum mismatch:
  - Stimulus: a one-word image with checksum 0x27.
  - Required response: `error`=1, `cpu_hold`=1, `done`=0. A following `start` with a valid image reaches DONE and clears `error`.
- Backpressure and gaps:
  - Stimulus: randomly deassert `in_valid`, and hold `in_valid` high during WRITE.
  - Required response: no byte is dropped or duplicated. `in_ready` is 0 during every `IM_we` cycle, and the memory contents match the image.
- Ignored `start`:
  - Stimulus: pulse `start` during HI and during CHECK.
  - Required response: the load continues unaffected, with the same write sequence and the same final state as without the pulses.
